// File: rtl/lv_bist_seq.sv
// LV built-in self test sequencer: analog BIST handover, then logic BIST,
// with per-phase timeouts and a sticky pass flag plus failure code.
module lv_bist_seq #(
  parameter int CLK_M        = 48,
  parameter int ABIST_TMO_US = 100,
  parameter int LBIST_TMO_US = 500
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_bist_req,
  input  logic       i_bist_abort,
  input  logic       i_lbist_en,
  input  logic       i_lv_abist_rult,
  input  logic       i_lbist_done,
  input  logic       i_lbist_pass,
  output logic       o_bist_en,
  output logic       o_lbist_start,
  output logic       o_bist_busy,
  output logic       o_bist_done,
  output logic       o_bist_pass,
  output logic [3:0] o_bist_fail_code
);

  localparam int ABIST_TMO_CYC = ABIST_TMO_US * CLK_M;
  localparam int LBIST_TMO_CYC = LBIST_TMO_US * CLK_M;
  localparam int MAX_TMO_CYC   = (ABIST_TMO_CYC > LBIST_TMO_CYC) ? ABIST_TMO_CYC : LBIST_TMO_CYC;
  localparam int CNT_W         = $clog2(MAX_TMO_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ABIST_TMO = CNT_W'(ABIST_TMO_CYC);
  localparam logic [CNT_W-1:0] LBIST_TMO = CNT_W'(LBIST_TMO_CYC);

  localparam logic [3:0] FC_ANALOG  = 4'b0001;
  localparam logic [3:0] FC_LOGIC   = 4'b0010;
  localparam logic [3:0] FC_TIMEOUT = 4'b0100;
  localparam logic [3:0] FC_ABORT   = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ABIST  = 2'd1,
    ST_LBIST  = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [3:0]       code_r;
  logic [3:0]       code_nxt_s;

  logic             bist_en_r;
  logic             lbist_start_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic [3:0]       fail_code_r;

  // Saturating increment so a long phase can never wrap back below the timeout
  assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

  // Next-state, counter and internal failure code; abort outranks everything,
  // a real handover or done outranks a coincident timeout
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    code_nxt_s  = code_r;
    case (state_r)
      ST_IDLE: begin
        if (i_bist_req) begin
          state_nxt_s = ST_ABIST;
          cnt_nxt_s   = CNT_ZERO;
          code_nxt_s  = 4'b0000;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ABIST: begin
        cnt_nxt_s = cnt_inc_s;
        if (i_bist_abort) begin
          state_nxt_s = ST_REPORT;
          code_nxt_s  = code_r | FC_ABORT;
        end else if (i_lbist_en) begin
          state_nxt_s = ST_LBIST;
          cnt_nxt_s   = CNT_ZERO;
          code_nxt_s  = {code_r[3:1], ~i_lv_abist_rult};
        end else if (cnt_r >= ABIST_TMO) begin
          state_nxt_s = ST_REPORT;
          code_nxt_s  = code_r | FC_TIMEOUT | FC_ANALOG;
        end else begin
          state_nxt_s = ST_ABIST;
        end
      end
      ST_LBIST: begin
        cnt_nxt_s = cnt_inc_s;
        if (i_bist_abort) begin
          state_nxt_s = ST_REPORT;
          code_nxt_s  = code_r | FC_ABORT;
        end else if (i_lbist_done) begin
          state_nxt_s = ST_REPORT;
          code_nxt_s  = {code_r[3:2], ~i_lbist_pass, code_r[0]};
        end else if (cnt_r >= LBIST_TMO) begin
          state_nxt_s = ST_REPORT;
          code_nxt_s  = code_r | FC_TIMEOUT | FC_LOGIC;
        end else begin
          state_nxt_s = ST_LBIST;
        end
      end
      ST_REPORT: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
        code_nxt_s  = 4'b0000;
      end
    endcase
  end

  // State, counter and code registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      code_r  <= 4'b0000;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      code_r  <= code_nxt_s;
    end
  end

  // Outputs are decoded from the next state so they change on the transition edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bist_en_r     <= 1'b0;
      lbist_start_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
      fail_code_r   <= 4'b0000;
    end else begin
      bist_en_r     <= (state_nxt_s == ST_ABIST) || (state_nxt_s == ST_LBIST);
      lbist_start_r <= (state_r == ST_ABIST) && (state_nxt_s == ST_LBIST);
      busy_r        <= (state_nxt_s != ST_IDLE);
      done_r        <= (state_nxt_s == ST_REPORT);
      if (state_nxt_s == ST_REPORT) begin
        fail_code_r <= code_nxt_s;
        pass_r      <= (code_nxt_s == 4'b0000);
      end else begin
        fail_code_r <= fail_code_r;
        pass_r      <= pass_r;
      end
    end
  end

  assign o_bist_en        = bist_en_r;
  assign o_lbist_start    = lbist_start_r;
  assign o_bist_busy      = busy_r;
  assign o_bist_done      = done_r;
  assign o_bist_pass      = pass_r;
  assign o_bist_fail_code = fail_code_r;

endmodule

// File: tb/tb_lv_bist_seq.sv
// Bench for lv_bist_seq: table of full sequences with hand-computed report
// times and codes, plus hand-written reset/restart/ignored-input sequences.
module tb_lv_bist_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bist_req = 1'b0;
  logic       bist_abort = 1'b0;
  logic       lbist_en = 1'b0;
  logic       abist_rult = 1'b0;
  logic       lbist_done = 1'b0;
  logic       lbist_pass = 1'b0;
  logic       bist_en;
  logic       lbist_start;
  logic       bist_busy;
  logic       bist_done;
  logic       bist_pass;
  logic [3:0] fail_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lv_bist_seq dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_bist_req       (bist_req),
    .i_bist_abort     (bist_abort),
    .i_lbist_en       (lbist_en),
    .i_lv_abist_rult  (abist_rult),
    .i_lbist_done     (lbist_done),
    .i_lbist_pass     (lbist_pass),
    .o_bist_en        (bist_en),
    .o_lbist_start    (lbist_start),
    .o_bist_busy      (bist_busy),
    .o_bist_done      (bist_done),
    .o_bist_pass      (bist_pass),
    .o_bist_fail_code (fail_code)
  );

  // hand:     ABIST counter value at which handover is driven (-1 = never)
  // done_off: LBIST counter value at which done is driven (-1 = never)
  // abort_at: cycle index since ABIST entry at which abort is driven (-1 = never)
  // exp_done: edge index (ABIST entry edge = 0) of the o_bist_done pulse
  typedef struct {
    string      name;
    int         hand;
    bit         rult;
    int         done_off;
    bit         lpass;
    int         abort_at;
    int         exp_done;
    logic [3:0] exp_code;
    bit         exp_pass;
    int         exp_starts;
  } vec_t;

  vec_t vecs[8];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input logic [3:0] prev_code, input bit prev_pass);
    int t;
    int lb_t;
    int done_t;
    int starts;
    int en_drop;
    t = 0; lb_t = -1; done_t = -1; starts = 0; en_drop = 0;
    bist_req = 1'b1;
    step;
    bist_req = 1'b0;
    chk({v.name, ":en_on"}, bist_en, 1);
    chk({v.name, ":busy_on"}, bist_busy, 1);
    chk({v.name, ":sticky_code"}, fail_code, prev_code);
    chk({v.name, ":sticky_pass"}, bist_pass, prev_pass);
    while (done_t < 0 && t < 30000) begin
      lbist_en   = (lb_t < 0 && v.hand == t);
      abist_rult = v.rult;
      lbist_done = (lb_t >= 0 && v.done_off >= 0 && (t - lb_t) == v.done_off);
      lbist_pass = v.lpass;
      bist_abort = (v.abort_at == t);
      step;
      t++;
      lbist_en = 1'b0; lbist_done = 1'b0; bist_abort = 1'b0;
      if (lbist_start) begin
        starts++;
        if (lb_t < 0) lb_t = t;
      end
      if (bist_done) done_t = t;
      else if (!bist_en) en_drop++;
    end
    chk({v.name, ":done_time"}, done_t, v.exp_done);
    chk({v.name, ":code"}, fail_code, v.exp_code);
    chk({v.name, ":pass"}, bist_pass, v.exp_pass);
    chk({v.name, ":en_off_report"}, bist_en, 0);
    chk({v.name, ":start_pulses"}, starts, v.exp_starts);
    chk({v.name, ":start_time"}, lb_t, (v.hand >= 0) ? v.hand + 1 : -1);
    chk({v.name, ":en_drop"}, en_drop, 0);
    step;
    chk({v.name, ":done_1cyc"}, bist_done, 0);
    chk({v.name, ":busy_off"}, bist_busy, 0);
    chk({v.name, ":code_held"}, fail_code, v.exp_code);
  endtask

  initial begin
    logic [3:0] prev_code;
    bit         prev_pass;

    vecs[0] = '{"nominal",     3361, 1'b1, 200, 1'b1, -1,  3563, 4'b0000, 1'b1, 1};
    vecs[1] = '{"analog_fail", 3361, 1'b0, 200, 1'b1, -1,  3563, 4'b0001, 1'b0, 1};
    vecs[2] = '{"abist_tmo",   -1,   1'b1, -1,  1'b1, -1,  4801, 4'b0101, 1'b0, 0};
    vecs[3] = '{"nominal2",    20,   1'b1, 3,   1'b1, -1,  25,   4'b0000, 1'b1, 1};
    vecs[4] = '{"lbist_tmo",   10,   1'b1, -1,  1'b1, -1,  24012, 4'b0110, 1'b0, 1};
    vecs[5] = '{"done_abort",  100,  1'b1, 50,  1'b1, 151, 152,  4'b1000, 1'b0, 1};
    vecs[6] = '{"hand_at_tmo", 4800, 1'b1, 5,   1'b1, -1,  4807, 4'b0000, 1'b1, 1};
    vecs[7] = '{"logic_fail",  50,   1'b1, 10,  1'b0, -1,  62,   4'b0010, 1'b0, 1};

    step;
    step;
    chk("rst:en", bist_en, 0);
    chk("rst:start", lbist_start, 0);
    chk("rst:busy", bist_busy, 0);
    chk("rst:done", bist_done, 0);
    chk("rst:pass", bist_pass, 0);
    chk("rst:code", fail_code, 0);
    rst = 1'b0;
    step;
    lbist_done = 1'b1;
    step;
    lbist_done = 1'b0;
    chk("idle_done_ignored", bist_busy, 0);

    prev_code = 4'b0000;
    prev_pass = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], prev_code, prev_pass);
      prev_code = vecs[i].exp_code;
      prev_pass = vecs[i].exp_pass;
    end

    // abort during ABIST
    bist_req = 1'b1;
    step;
    bist_req = 1'b0;
    step; step;
    bist_abort = 1'b1;
    lbist_en = 1'b1;
    step;
    bist_abort = 1'b0;
    lbist_en = 1'b0;
    chk("abist_abort:done", bist_done, 1);
    chk("abist_abort:code", fail_code, 4'b1000);
    chk("abist_abort:start", lbist_start, 0);
    step;

    // asynchronous reset in the middle of LBIST
    bist_req = 1'b1;
    step;
    bist_req = 1'b0;
    repeat (5) step;
    lbist_en = 1'b1; abist_rult = 1'b1;
    step;
    lbist_en = 1'b0;
    chk("rstmid:start", lbist_start, 1);
    repeat (10) step;
    rst = 1'b1;
    #2;
    chk("rstmid:en", bist_en, 0);
    chk("rstmid:busy", bist_busy, 0);
    chk("rstmid:start0", lbist_start, 0);
    chk("rstmid:pass", bist_pass, 0);
    chk("rstmid:code", fail_code, 0);
    step;
    rst = 1'b0;
    step;
    chk("rstmid:idle", bist_busy, 0);

    // held request: ignored while busy, spurious done in ABIST ignored,
    // then a restart one cycle after the report
    bist_req = 1'b1;
    step;
    chk("held:en_on", bist_en, 1);
    lbist_done = 1'b1; lbist_pass = 1'b0;
    step;
    lbist_done = 1'b0; lbist_pass = 1'b1;
    chk("held:abist_done_ignored", bist_done, 0);
    step;
    lbist_en = 1'b1;
    step;
    lbist_en = 1'b0;
    chk("held:start", lbist_start, 1);
    step;
    chk("held:start_1cyc", lbist_start, 0);
    repeat (4) step;
    chk("held:no_restart", bist_en, 1);
    lbist_done = 1'b1;
    step;
    lbist_done = 1'b0;
    chk("held:done", bist_done, 1);
    chk("held:pass", bist_pass, 1);
    chk("held:code", fail_code, 0);
    step;
    chk("held:idle_gap", bist_busy, 0);
    step;
    chk("held:restart_busy", bist_busy, 1);
    chk("held:restart_en", bist_en, 1);
    bist_req = 1'b0;
    bist_abort = 1'b1;
    step;
    bist_abort = 1'b0;
    chk("held:abort_code", fail_code, 4'b1000);
    step;
    chk("held:final_idle", bist_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
